hssl_apb_arbiter: RTL and testbench
===================================

HSSL_APB_ARBITER -- requirements
Module: hssl_apb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles without m_pready_in before a transfer is aborted (range 1..255).
REQ-002 SHALL have parameter ERR_DATA, default 32'hdead_beef, meaning the value returned on s_prdata_out for an aborted read.
REQ-003 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_psel_in  input  [1:0]  per-requester APB select, bit i = requester i.
REQ-006 SHALL have port s_penable_in  input  [1:0]  per-requester APB enable.
REQ-007 SHALL have port s_pwrite_in  input  [1:0]  per-requester write flag.
REQ-008 SHALL have port s_paddr_in  input  2 x [39:0]  per-requester address, as an unpacked array indexed by requester.
REQ-009 SHALL have port s_pwdata_in  input  2 x [31:0]  per-requester write data.
REQ-010 SHALL have port s_prdata_out  output  [31:0]  read data, shared by both requesters and valid with s_pready_out.
REQ-011 SHALL have port s_pready_out  output  [1:0]  per-requester ready.
REQ-012 SHALL have port s_pslverr_out  output  [1:0]  per-requester slave error.
REQ-013 SHALL have ports m_psel_out, m_penable_out, m_pwrite_out (1 bit each), m_paddr_out [39:0] and m_pwdata_out [31:0]  output  the APB master port to the register bank.
REQ-014 SHALL have ports m_prdata_in [31:0], m_pready_in and m_pslverr_in (1 bit each)  input  the register bank responses.
REQ-015 SHALL have port busy_out  output  1  high whenever the FSM is not in IDLE.
REQ-016 SHALL have port err_count_out  output  [7:0]  saturating count of aborted transfers.

Function
REQ-017 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, all registered.
REQ-018 In IDLE, when any s_psel_in bit is 1, the block SHALL grant one requester, latch its pwrite/paddr/pwdata into the master registers, and go to SETUP.
REQ-019 Arbitration SHALL be round-robin: if only one requester is asserted, it wins; if both are asserted, the requester not equal to last_grant wins; last_grant SHALL update at the RESP->IDLE edge.
REQ-020 In SETUP, the block SHALL drive m_psel=1 and m_penable=0 for exactly one cycle, then go to ACCESS.
REQ-021 In ACCESS, the block SHALL drive m_psel=1 and m_penable=1; on m_pready_in=1 it SHALL capture m_prdata_in and m_pslverr_in, then go to RESP.
REQ-022 In ACCESS, an 8-bit counter SHALL start at 0 on entry and increment each cycle without m_pready_in; on reaching TIMEOUT_CYCLES it SHALL go to RESP with an abort flag, pslverr=1 and prdata=ERR_DATA.
REQ-023 m_psel and m_penable SHALL deassert in RESP and IDLE; m_paddr, m_pwdata and m_pwrite SHALL hold their last value.
REQ-024 In RESP, the block SHALL drive s_pready_out[g]=1 for exactly one cycle, plus s_pslverr_out[g] and s_prdata_out (the latter for reads only; writes return 0); it SHALL then go to IDLE.
REQ-025 The non-granted requester's pready and pslverr SHALL stay 0 throughout, which holds it in its APB wait state.
REQ-026 Minimum latency SHALL be as follows: with psel sampled at edge t, the master setup phase occupies cycle t+1, access t+2, s_pready is high in t+3, and IDLE resumes at t+4.
REQ-027 A new grant SHALL be taken only in IDLE, so there are no back-to-back grants without an intervening IDLE cycle.
REQ-028 If the granted requester drops psel mid-transfer, the master transfer and the RESP pulse SHALL still complete.
REQ-029 err_count SHALL increment by 1 on each abort and saturate at 8'hff.
REQ-030 A master response of m_pslverr_in=1 SHALL be forwarded to the requester and SHALL NOT count as an abort.

Reset
REQ-031 When resetn=0, the block SHALL asynchronously force: state IDLE; all m_* outputs 0; s_prdata 0; s_pready and s_pslverr 2'b00; err_count 0; timeout counter 0; last_grant 1 (requester 0 wins the first tie); busy 0.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no RESP pulse, and the first post-reset grant SHALL follow REQ-018.

Verification
REQ-033 Scenario: requester 0 writes addr 40'h40, data 32'h1234_5678, with slave pready held at 1 -> m_paddr=40'h40 and m_pwdata=32'h1234_5678 in SETUP and ACCESS; s_pready_out=2'b01 for one cycle at t+3; s_pslverr=0.
REQ-034 Scenario: requester 1 reads addr 40'h00 while the slave returns 32'hfeed_cafe with pready=1 -> s_prdata_out=32'hfeed_cafe with s_pready_out=2'b10; s_pslverr_out=0.
REQ-035 Scenario: both requesters assert psel on the same edge after reset -> requester 0 is served first, then requester 1, and each sees exactly one pready pulse.
REQ-036 Scenario: slave pready held at 0 with TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles, s_pslverr=1, read data=32'hdead_beef, and err_count=1; 256 aborts leave err_count=8'hff.
REQ-037 Scenario: resetn pulsed low during ACCESS -> all outputs are 0 immediately, there is no s_pready pulse, and a subsequent request completes normally.

Source files
------------

// File: rtl/hssl_apb_arbiter.sv
// Two-requester APB arbiter feeding a single APB master port to the register bank.
// Round-robin grant in IDLE, one master transfer per grant, with an ACCESS-phase timeout abort.
module hssl_apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hdead_beef
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  s_psel_in,
  input  logic [1:0]  s_penable_in,
  input  logic [1:0]  s_pwrite_in,
  input  logic [39:0] s_paddr_in [2],
  input  logic [31:0] s_pwdata_in [2],
  output logic [31:0] s_prdata_out,
  output logic [1:0]  s_pready_out,
  output logic [1:0]  s_pslverr_out,
  output logic        m_psel_out,
  output logic        m_penable_out,
  output logic        m_pwrite_out,
  output logic [39:0] m_paddr_out,
  output logic [31:0] m_pwdata_out,
  input  logic [31:0] m_prdata_in,
  input  logic        m_pready_in,
  input  logic        m_pslverr_in,
  output logic        busy_out,
  output logic [7:0]  err_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q,      state_d;
  logic        grant_q,      grant_d;
  logic        last_grant_q, last_grant_d;
  logic        m_pwrite_q,   m_pwrite_d;
  logic [39:0] m_paddr_q,    m_paddr_d;
  logic [31:0] m_pwdata_q,   m_pwdata_d;
  logic [31:0] rdata_q,      rdata_d;
  logic        slverr_q,     slverr_d;
  logic [7:0]  tmo_cnt_q,    tmo_cnt_d;
  logic [7:0]  err_cnt_q,    err_cnt_d;

  logic        req_win;
  logic [7:0]  tmo_inc;

  // The requester-side enable carries no information the arbiter needs: a
  // request is fully described by psel in IDLE.
  logic unused_penable;
  assign unused_penable = ^s_penable_in;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    req_win = 1'b0;
    unique case (s_psel_in)
      2'b01:   req_win = 1'b0;
      2'b10:   req_win = 1'b1;
      2'b11:   req_win = ~last_grant_q;
      default: req_win = 1'b0;
    endcase
  end

  assign tmo_inc = tmo_cnt_q + 8'd1;

  // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_pwrite_d   = m_pwrite_q;
    m_paddr_d    = m_paddr_q;
    m_pwdata_d   = m_pwdata_q;
    rdata_d      = rdata_q;
    slverr_d     = slverr_q;
    tmo_cnt_d    = tmo_cnt_q;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s_psel_in != 2'b00) begin
          grant_d    = req_win;
          m_pwrite_d = s_pwrite_in[req_win];
          m_paddr_d  = s_paddr_in[req_win];
          m_pwdata_d = s_pwdata_in[req_win];
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        tmo_cnt_d = 8'd0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (m_pready_in) begin
          rdata_d  = m_pwrite_q ? 32'd0 : m_prdata_in;
          slverr_d = m_pslverr_in;
          state_d  = ST_RESP;
        end else if (tmo_inc == TMO_LIMIT) begin
          // Abort: the bank never answered, fabricate an error response.
          tmo_cnt_d = tmo_inc;
          rdata_d   = m_pwrite_q ? 32'd0 : ERR_DATA;
          slverr_d  = 1'b1;
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d   = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_pwrite_q   <= 1'b0;
      m_paddr_q    <= 40'd0;
      m_pwdata_q   <= 32'd0;
      rdata_q      <= 32'd0;
      slverr_q     <= 1'b0;
      tmo_cnt_q    <= 8'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_pwrite_q   <= m_pwrite_d;
      m_paddr_q    <= m_paddr_d;
      m_pwdata_q   <= m_pwdata_d;
      rdata_q      <= rdata_d;
      slverr_q     <= slverr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Response outputs are gated by RESP so the ungranted requester stays in its wait state.
  assign m_psel_out    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign m_penable_out = (state_q == ST_ACCESS);
  assign m_pwrite_out  = m_pwrite_q;
  assign m_paddr_out   = m_paddr_q;
  assign m_pwdata_out  = m_pwdata_q;

  assign s_pready_out  = (state_q == ST_RESP) ? {grant_q, ~grant_q} : 2'b00;
  assign s_pslverr_out = (state_q == ST_RESP) ? ({grant_q, ~grant_q} & {2{slverr_q}}) : 2'b00;
  assign s_prdata_out  = (state_q == ST_RESP) ? rdata_q : 32'd0;

  assign busy_out      = (state_q != ST_IDLE);
  assign err_count_out = err_cnt_q;

endmodule

// File: tb/tb_hssl_apb_arbiter.sv
// Directed bench for hssl_apb_arbiter: single transfers, round-robin ties,
// slave error forwarding, timeout aborts with counter saturation, and mid-transfer reset.
module tb_hssl_apb_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  s_psel_in;
  logic [1:0]  s_penable_in;
  logic [1:0]  s_pwrite_in;
  logic [39:0] s_paddr_in [2];
  logic [31:0] s_pwdata_in [2];
  logic [31:0] s_prdata_out;
  logic [1:0]  s_pready_out;
  logic [1:0]  s_pslverr_out;
  logic        m_psel_out;
  logic        m_penable_out;
  logic        m_pwrite_out;
  logic [39:0] m_paddr_out;
  logic [31:0] m_pwdata_out;
  logic [31:0] m_prdata_in;
  logic        m_pready_in;
  logic        m_pslverr_in;
  logic        busy_out;
  logic [7:0]  err_count_out;

  int n_cmp  = 0;
  int n_fail = 0;

  hssl_apb_arbiter dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_psel_in     (s_psel_in),
    .s_penable_in  (s_penable_in),
    .s_pwrite_in   (s_pwrite_in),
    .s_paddr_in    (s_paddr_in),
    .s_pwdata_in   (s_pwdata_in),
    .s_prdata_out  (s_prdata_out),
    .s_pready_out  (s_pready_out),
    .s_pslverr_out (s_pslverr_out),
    .m_psel_out    (m_psel_out),
    .m_penable_out (m_penable_out),
    .m_pwrite_out  (m_pwrite_out),
    .m_paddr_out   (m_paddr_out),
    .m_pwdata_out  (m_pwdata_out),
    .m_prdata_in   (m_prdata_in),
    .m_pready_in   (m_pready_in),
    .m_pslverr_in  (m_pslverr_in),
    .busy_out      (busy_out),
    .err_count_out (err_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request from requester r (called at a negedge) and watches for its pready pulse.
  task automatic run_txn(input string tag, input int r, input logic wr, input logic [39:0] a,
                         input logic [31:0] wd, output int pulses, output logic [1:0] rdy,
                         output logic [1:0] err, output logic [31:0] rd);
    bit seen;
    int after;
    seen   = 1'b0;
    after  = 0;
    pulses = 0;
    rdy    = 2'b00;
    err    = 2'b00;
    rd     = 32'd0;
    s_psel_in[r]    = 1'b1;
    s_penable_in[r] = 1'b0;
    s_pwrite_in[r]  = wr;
    s_paddr_in[r]   = a;
    s_pwdata_in[r]  = wd;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_pready_out != 2'b00) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          rdy  = s_pready_out;
          err  = s_pslverr_out;
          rd   = s_prdata_out;
          s_psel_in[r]    = 1'b0;
          s_penable_in[r] = 1'b0;
        end
      end else if (seen) begin
        after++;
        if (after == 2) break;
      end else begin
        s_penable_in[r] = 1'b1;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  // Both requesters ask at once; f is the one expected to be served first.
  task automatic tie_pair(input string tag, input int f);
    s_psel_in      = 2'b11;
    s_pwrite_in    = 2'b00;
    s_paddr_in[0]  = 40'h100;
    s_paddr_in[1]  = 40'h200;
    m_pready_in    = 1'b1;
    @(negedge clk);
    check({tag, "_first_addr"}, 64'(m_paddr_out), (f == 0) ? 64'h100 : 64'h200);
    check({tag, "_setup_nordy"}, 64'(s_pready_out), 64'd0);
    @(negedge clk);
    check({tag, "_access_nordy"}, 64'(s_pready_out), 64'd0);
    @(negedge clk);
    check({tag, "_first_rdy"}, 64'(s_pready_out), (f == 0) ? 64'd1 : 64'd2);
    s_psel_in[f] = 1'b0;
    @(negedge clk);
    check({tag, "_gap_nordy"}, 64'(s_pready_out), 64'd0);
    check({tag, "_gap_idle"}, 64'(busy_out), 64'd0);
    @(negedge clk);
    check({tag, "_second_addr"}, 64'(m_paddr_out), (f == 0) ? 64'h200 : 64'h100);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_second_rdy"}, 64'(s_pready_out), (f == 0) ? 64'd2 : 64'd1);
    s_psel_in = 2'b00;
    @(negedge clk);
    check({tag, "_end_nordy"}, 64'(s_pready_out), 64'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  int          pulses;
  logic [1:0]  rdy;
  logic [1:0]  err;
  logic [31:0] rd;

  initial begin
    resetn         = 1'b0;
    s_psel_in      = 2'b00;
    s_penable_in   = 2'b00;
    s_pwrite_in    = 2'b00;
    s_paddr_in[0]  = 40'd0;
    s_paddr_in[1]  = 40'd0;
    s_pwdata_in[0] = 32'd0;
    s_pwdata_in[1] = 32'd0;
    m_prdata_in    = 32'd0;
    m_pready_in    = 1'b1;
    m_pslverr_in   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_m_psel",    64'(m_psel_out),    64'd0);
    check("rst_m_penable", 64'(m_penable_out), 64'd0);
    check("rst_m_pwrite",  64'(m_pwrite_out),  64'd0);
    check("rst_m_paddr",   64'(m_paddr_out),   64'd0);
    check("rst_m_pwdata",  64'(m_pwdata_out),  64'd0);
    check("rst_prdata",    64'(s_prdata_out),  64'd0);
    check("rst_pready",    64'(s_pready_out),  64'd0);
    check("rst_pslverr",   64'(s_pslverr_out), 64'd0);
    check("rst_busy",      64'(busy_out),      64'd0);
    check("rst_errcnt",    64'(err_count_out), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Requester 0 write, cycle by cycle.
    s_psel_in      = 2'b01;
    s_pwrite_in[0] = 1'b1;
    s_paddr_in[0]  = 40'h40;
    s_pwdata_in[0] = 32'h1234_5678;
    @(negedge clk);
    check("wr_setup_psel",    64'(m_psel_out),    64'd1);
    check("wr_setup_penable", 64'(m_penable_out), 64'd0);
    check("wr_setup_paddr",   64'(m_paddr_out),   64'h40);
    check("wr_setup_pwdata",  64'(m_pwdata_out),  64'h1234_5678);
    check("wr_setup_pwrite",  64'(m_pwrite_out),  64'd1);
    check("wr_setup_busy",    64'(busy_out),      64'd1);
    check("wr_setup_nordy",   64'(s_pready_out),  64'd0);
    @(negedge clk);
    check("wr_access_psel",    64'(m_psel_out),    64'd1);
    check("wr_access_penable", 64'(m_penable_out), 64'd1);
    check("wr_access_paddr",   64'(m_paddr_out),   64'h40);
    check("wr_access_pwdata",  64'(m_pwdata_out),  64'h1234_5678);
    check("wr_access_nordy",   64'(s_pready_out),  64'd0);
    @(negedge clk);
    check("wr_resp_rdy",    64'(s_pready_out),  64'd1);
    check("wr_resp_err",    64'(s_pslverr_out), 64'd0);
    check("wr_resp_rdata",  64'(s_prdata_out),  64'd0);
    check("wr_resp_psel",   64'(m_psel_out),    64'd0);
    check("wr_resp_pen",    64'(m_penable_out), 64'd0);
    s_psel_in = 2'b00;
    @(negedge clk);
    check("wr_idle_rdy",   64'(s_pready_out), 64'd0);
    check("wr_idle_busy",  64'(busy_out),     64'd0);
    check("wr_hold_paddr", 64'(m_paddr_out),  64'h40);
    check("wr_hold_pwr",   64'(m_pwrite_out), 64'd1);

    // Requester 1 read.
    m_prdata_in = 32'hfeed_cafe;
    run_txn("rd1", 1, 1'b0, 40'h00, 32'd0, pulses, rdy, err, rd);
    check("rd1_pulses", 64'(pulses), 64'd1);
    check("rd1_rdy",    64'(rdy),    64'd2);
    check("rd1_err",    64'(err),    64'd0);
    check("rd1_rdata",  64'(rd),     64'hfeed_cafe);

    // Tie right after reset: requester 0 first.
    do_reset();
    tie_pair("tie_rst", 0);

    // Requester 0 alone, then a tie: requester 1 first.
    m_prdata_in = 32'h1111_2222;
    run_txn("solo0", 0, 1'b0, 40'h08, 32'd0, pulses, rdy, err, rd);
    check("solo0_rdata", 64'(rd), 64'h1111_2222);
    tie_pair("tie_rr", 1);

    // Slave error is forwarded, not counted as an abort.
    m_pslverr_in = 1'b1;
    m_prdata_in  = 32'h5555_aaaa;
    run_txn("slverr", 0, 1'b0, 40'h10, 32'd0, pulses, rdy, err, rd);
    check("slverr_rdy",    64'(rdy),           64'd1);
    check("slverr_err",    64'(err),           64'd1);
    check("slverr_rdata",  64'(rd),            64'h5555_aaaa);
    check("slverr_errcnt", 64'(err_count_out), 64'd0);
    m_pslverr_in = 1'b0;

    // Timeout: 16 ACCESS cycles then an abort response.
    m_pready_in    = 1'b0;
    s_psel_in      = 2'b01;
    s_pwrite_in[0] = 1'b0;
    s_paddr_in[0]  = 40'h20;
    @(negedge clk);
    check("tmo_setup_pen", 64'(m_penable_out), 64'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1 || i == 16) begin
        check($sformatf("tmo_access%0d_pen", i), 64'(m_penable_out), 64'd1);
        check($sformatf("tmo_access%0d_nordy", i), 64'(s_pready_out), 64'd0);
      end
    end
    @(negedge clk);
    check("tmo_rdy",    64'(s_pready_out),  64'd1);
    check("tmo_err",    64'(s_pslverr_out), 64'd1);
    check("tmo_rdata",  64'(s_prdata_out),  64'hdead_beef);
    check("tmo_errcnt", 64'(err_count_out), 64'd1);
    s_psel_in = 2'b00;
    @(negedge clk);

    // Aborted write returns zero data.
    run_txn("tmo_wr", 1, 1'b1, 40'h30, 32'h0bad_0bad, pulses, rdy, err, rd);
    check("tmo_wr_err",   64'(err), 64'd2);
    check("tmo_wr_rdata", 64'(rd),  64'd0);

    // Saturation of the abort counter: 254, 255, then 256 aborts.
    for (int i = 3; i <= 254; i++) begin
      run_txn($sformatf("abort%0d", i), 0, 1'b0, 40'h20, 32'd0, pulses, rdy, err, rd);
    end
    check("errcnt_254", 64'(err_count_out), 64'hfe);
    run_txn("abort255", 1, 1'b0, 40'h20, 32'd0, pulses, rdy, err, rd);
    check("errcnt_255", 64'(err_count_out), 64'hff);
    run_txn("abort256", 0, 1'b0, 40'h20, 32'd0, pulses, rdy, err, rd);
    check("errcnt_256", 64'(err_count_out), 64'hff);
    check("abort256_pulses", 64'(pulses), 64'd1);

    // Reset during ACCESS.
    s_psel_in      = 2'b01;
    s_pwrite_in[0] = 1'b1;
    s_paddr_in[0]  = 40'h55;
    s_pwdata_in[0] = 32'h7777_8888;
    @(negedge clk);
    @(negedge clk);
    check("mid_access_pen", 64'(m_penable_out), 64'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_psel",    64'(m_psel_out),    64'd0);
    check("mid_rst_pen",     64'(m_penable_out), 64'd0);
    check("mid_rst_paddr",   64'(m_paddr_out),   64'd0);
    check("mid_rst_pwdata",  64'(m_pwdata_out),  64'd0);
    check("mid_rst_pwrite",  64'(m_pwrite_out),  64'd0);
    check("mid_rst_rdy",     64'(s_pready_out),  64'd0);
    check("mid_rst_busy",    64'(busy_out),      64'd0);
    check("mid_rst_errcnt",  64'(err_count_out), 64'd0);
    s_psel_in = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_rst_nordy%0d", i), 64'(s_pready_out), 64'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_nordy", 64'(s_pready_out), 64'd0);
    m_pready_in = 1'b1;
    run_txn("post_rst", 1, 1'b1, 40'h60, 32'h0102_0304, pulses, rdy, err, rd);
    check("post_rst_pulses", 64'(pulses), 64'd1);
    check("post_rst_rdy",    64'(rdy),    64'd2);
    check("post_rst_err",    64'(err),    64'd0);
    check("post_rst_paddr",  64'(m_paddr_out),  64'h60);
    check("post_rst_pwdata", 64'(m_pwdata_out), 64'h0102_0304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
